bitwise_pipe: RTL and testbench
===============================

BITWISE_PIPE -- requirements
Module: bitwise_pipe

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width in bits (legal range 1..64).
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 in_valid  input  1  operand beat present.
REQ-005 in_ready  output  1  block accepts operand beat this cycle.
REQ-006 a  input  WIDTH  operand A.
REQ-007 b  input  WIDTH  operand B.
REQ-008 op  input  2  operation: 00 AND, 01 OR, 10 XOR, 11 NOR.
REQ-009 acc_en  input  1  substitute internal accumulator for A; write result back to accumulator.
REQ-010 acc_clr  input  1  synchronous accumulator clear.
REQ-011 out_valid  output  1  result beat present.
REQ-012 out_ready  input  1  consumer accepts result beat.
REQ-013 result  output  WIDTH  operation result.
REQ-014 zero  output  1  result is all zeros.
REQ-015 parity  output  1  XOR-reduction of result.

Function
REQ-016 Two register stages SHALL exist: S1 (captured a, b, op, acc_en) and S2 (result, zero, parity); each has its own valid bit.
REQ-017 Input transfer SHALL occur on a clk edge when in_valid and in_ready are both 1; output transfer when out_valid and out_ready are both 1.
REQ-018 S2 SHALL load from S1 when S1 valid and (S2 empty or output transfer this cycle).
REQ-019 in_ready SHALL equal (S1 empty) or (S1 loading into S2 this cycle); combinational from out_ready, no combinational path from in_valid.
REQ-020 S1 SHALL load on input transfer; it SHALL become empty when it loads into S2 without a simultaneous input transfer.
REQ-021 Latency SHALL be 2 cycles: a beat accepted at edge N appears with out_valid=1 after edge N+1 when unstalled.
REQ-022 Throughput SHALL be one beat per cycle with out_ready held 1; no bubble insertion.
REQ-023 Computation SHALL occur in the S1-to-S2 transfer: operand X = acc_en_s1 ? acc : a_s1; result = X op b_s1, bitwise over WIDTH bits; NOR = ~(X | b_s1).
REQ-024 On an S1-to-S2 transfer with acc_en_s1=1, acc SHALL be loaded with the computed result in the same edge.
REQ-025 Back-to-back acc_en beats SHALL chain: each uses the accumulator value written by the preceding acc_en beat, with no stall.
REQ-026 acc_clr=1 SHALL force acc to 0 at the next edge; if coincident with an accumulator write, clear wins; the beat transferring that edge still uses the pre-clear acc value.
REQ-027 zero SHALL be 1 exactly when result == 0; parity SHALL be ^result; both registered with result.
REQ-028 While out_valid=1 and out_ready=0, result/zero/parity/out_valid SHALL hold stable; S1 SHALL hold; in_ready SHALL be 0 if S1 is full.
REQ-029 result, zero, parity SHALL retain their last value when S2 empties (no clearing on drain).
REQ-030 Beats SHALL leave in acceptance order; no beat dropped or duplicated under any valid/ready pattern.

Reset
REQ-031 On rst_n=0, asynchronously: S1/S2 valid=0, out_valid=0, result=0, zero=1, parity=0, acc=0, S1 data=0.
REQ-032 in_ready SHALL be 1 during and immediately after reset; reset mid-operation SHALL discard all in-flight beats.
REQ-033 First input transfer SHALL be possible at the first rising edge after rst_n deasserts.

Verification (WIDTH=32)
REQ-034 OR beat a=0xF0F0_0000, b=0x0000_0F0F, op=01, out_ready=1 -> 2 cycles later result=0xF0F0_0F0F, zero=0, parity=0.
REQ-035 Streams AND/OR/XOR/NOR on a=0xFFFF_0000, b=0x0F0F_0F0F back-to-back -> results 0x0F0F_0000, 0xFFFF_0F0F, 0xF0F0_0F0F, 0x0000_F0F0 in consecutive cycles.
REQ-036 acc_clr then acc_en OR beats b=0x1, 0x2, 0x4 -> results 0x1, 0x3, 0x7; acc=0x7.
REQ-037 out_ready=0 for 5 cycles with in_valid=1 -> exactly 2 beats accepted, in_ready=0, result stable; release -> all beats delivered in order.
REQ-038 XOR a=b=0xDEAD_BEEF -> result=0, zero=1, parity=0; NOR a=b=0 -> 0xFFFF_FFFF, parity=0.
REQ-039 rst_n pulsed low with both stages full -> out_valid=0, acc=0 immediately; next accepted beat is first output.

Source files
------------

// File: rtl/bitwise_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : bitwise_pipe
//  Purpose  : Two-stage valid/ready pipeline computing AND/OR/XOR/NOR with an
//             optional chained accumulator operand, plus zero/parity flags.
//  Revision : 1.0
// ============================================================================
module bitwise_pipe #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  input  logic             acc_en,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             parity
);

  localparam logic [1:0] c_op_and = 2'b00;
  localparam logic [1:0] c_op_or  = 2'b01;
  localparam logic [1:0] c_op_xor = 2'b10;
  localparam logic [1:0] c_op_nor = 2'b11;

  logic             r_s1_valid;
  logic [WIDTH-1:0] r_a_s1;
  logic [WIDTH-1:0] r_b_s1;
  logic [1:0]       r_op_s1;
  logic             r_acc_en_s1;
  logic [WIDTH-1:0] r_acc;

  logic             r_s2_valid;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic             r_parity;

  logic             w_s2_load;
  logic             w_in_xfer;
  logic [WIDTH-1:0] w_x;
  logic [WIDTH-1:0] w_res;

  // S1 may advance when S2 is empty or is being drained this same edge.
  assign w_s2_load = r_s1_valid && (!r_s2_valid || out_ready);
  assign in_ready  = !r_s1_valid || w_s2_load;
  assign w_in_xfer = in_valid && in_ready;

  assign w_x = r_acc_en_s1 ? r_acc : r_a_s1;

  always_comb begin
    w_res = '0;
    case (r_op_s1)
      c_op_and: w_res = w_x & r_b_s1;
      c_op_or:  w_res = w_x | r_b_s1;
      c_op_xor: w_res = w_x ^ r_b_s1;
      c_op_nor: w_res = ~(w_x | r_b_s1);
      default:  w_res = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid  <= 1'b0;
      r_a_s1      <= '0;
      r_b_s1      <= '0;
      r_op_s1     <= 2'b00;
      r_acc_en_s1 <= 1'b0;
    end else begin
      if (w_in_xfer) begin
        r_s1_valid  <= 1'b1;
        r_a_s1      <= a;
        r_b_s1      <= b;
        r_op_s1     <= op;
        r_acc_en_s1 <= acc_en;
      end else if (w_s2_load) begin
        r_s1_valid  <= 1'b0;
      end
    end
  end

  // Clear takes priority over a coincident write-back.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
    end else if (acc_clr) begin
      r_acc <= '0;
    end else if (w_s2_load && r_acc_en_s1) begin
      r_acc <= w_res;
    end
  end

  // Result registers deliberately keep their value once S2 drains.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_result   <= '0;
      r_zero     <= 1'b1;
      r_parity   <= 1'b0;
    end else begin
      if (w_s2_load) begin
        r_s2_valid <= 1'b1;
        r_result   <= w_res;
        r_zero     <= (w_res == '0);
        r_parity   <= ^w_res;
      end else if (out_ready) begin
        r_s2_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_s2_valid;
  assign result    = r_result;
  assign zero      = r_zero;
  assign parity    = r_parity;

endmodule
`default_nettype wire

// File: tb/tb_bitwise_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bitwise_pipe
//  Purpose  : Directed self-checking bench for bitwise_pipe (WIDTH=32).
//  Revision : 1.0
// ============================================================================
module tb_bitwise_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic [1:0]  op;
  logic        acc_en;
  logic        acc_clr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        parity;

  typedef struct packed {
    logic [31:0] res;
    logic        z;
    logic        p;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_errors = 0;

  bitwise_pipe #(.WIDTH(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .op       (op),
    .acc_en   (acc_en),
    .acc_clr  (acc_clr),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .zero     (zero),
    .parity   (parity)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [31:0] er, input logic ez, input logic ep);
    exp_t e;
    e.res = er;
    e.z   = ez;
    e.p   = ep;
    exp_q.push_back(e);
  endtask

  // Presents one beat and returns just after the edge that accepted it,
  // leaving in_valid asserted so consecutive calls stream back-to-back.
  task automatic send(input logic [31:0] ta, input logic [31:0] tb_v, input logic [1:0] top,
                      input logic ten, input logic [31:0] er, input logic ez, input logic ep);
    bit done = 1'b0;
    in_valid = 1'b1;
    a        = ta;
    b        = tb_v;
    op       = top;
    acc_en   = ten;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clk);
      if (in_ready) begin
        push_exp(er, ez, ep);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    if (!done) check("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic idle();
    in_valid = 1'b0;
    acc_en   = 1'b0;
    step();
  endtask

  task automatic drain();
    for (int k = 0; k < 30 && exp_q.size() != 0; k++) step();
    check("drain_left", 64'(exp_q.size()), 64'd0);
  endtask

  // Output monitor: every delivered beat must match the oldest expected one.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("extra_beat", 64'd1, 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("mon_result", 64'(result), 64'(mon_e.res));
        check("mon_zero",   64'(zero),   64'(mon_e.z));
        check("mon_parity", 64'(parity), 64'(mon_e.p));
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int accepted;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    op        = 2'b00;
    acc_en    = 1'b0;
    acc_clr   = 1'b0;
    out_ready = 1'b1;

    #12;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_result",    64'(result),    64'd0);
    check("rst_zero",      64'(zero),      64'd1);
    check("rst_parity",    64'(parity),    64'd0);
    check("rst_in_ready",  64'(in_ready),  64'd1);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    check("post_rst_in_ready", 64'(in_ready), 64'd1);

    // Single OR beat: latency and flags.
    send(32'hF0F0_0000, 32'h0000_0F0F, 2'b01, 1'b0, 32'hF0F0_0F0F, 1'b0, 1'b0);
    in_valid = 1'b0;
    check("lat_edge1_valid", 64'(out_valid), 64'd0);
    step();
    check("lat_edge2_valid", 64'(out_valid), 64'd1);
    check("or_result",       64'(result),    64'hF0F0_0F0F);
    check("or_zero",         64'(zero),      64'd0);
    check("or_parity",       64'(parity),    64'd0);
    drain();

    // Back-to-back stream of all four operations.
    send(32'hFFFF_0000, 32'h0F0F_0F0F, 2'b00, 1'b0, 32'h0F0F_0000, 1'b0, 1'b0);
    send(32'hFFFF_0000, 32'h0F0F_0F0F, 2'b01, 1'b0, 32'hFFFF_0F0F, 1'b0, 1'b0);
    check("stream_v0", 64'(out_valid), 64'd1);
    check("stream_r0", 64'(result),    64'h0F0F_0000);
    send(32'hFFFF_0000, 32'h0F0F_0F0F, 2'b10, 1'b0, 32'hF0F0_0F0F, 1'b0, 1'b0);
    check("stream_r1", 64'(result),    64'hFFFF_0F0F);
    send(32'hFFFF_0000, 32'h0F0F_0F0F, 2'b11, 1'b0, 32'h0000_F0F0, 1'b0, 1'b0);
    check("stream_r2", 64'(result),    64'hF0F0_0F0F);
    idle();
    check("stream_v3", 64'(out_valid), 64'd1);
    check("stream_r3", 64'(result),    64'h0000_F0F0);
    drain();

    // Accumulator chain; operand A must be ignored when acc_en is set.
    acc_clr = 1'b1;
    step();
    acc_clr = 1'b0;
    send(32'hFFFF_FFFF, 32'h1, 2'b01, 1'b1, 32'h1, 1'b0, 1'b1);
    send(32'hFFFF_FFFF, 32'h2, 2'b01, 1'b1, 32'h3, 1'b0, 1'b0);
    send(32'hFFFF_FFFF, 32'h4, 2'b01, 1'b1, 32'h7, 1'b0, 1'b1);
    send(32'hFFFF_FFFF, 32'h0, 2'b01, 1'b1, 32'h7, 1'b0, 1'b1);
    idle();
    drain();

    // Clear coincident with a write-back: beat sees old acc, clear wins.
    send(32'h0, 32'h8, 2'b01, 1'b1, 32'hF, 1'b0, 1'b0);
    in_valid = 1'b0;
    acc_en   = 1'b0;
    acc_clr  = 1'b1;
    step();
    acc_clr  = 1'b0;
    send(32'hFFFF_FFFF, 32'h0, 2'b01, 1'b1, 32'h0, 1'b1, 1'b0);
    idle();
    drain();

    // Zero / parity corners.
    send(32'hDEAD_BEEF, 32'hDEAD_BEEF, 2'b10, 1'b0, 32'h0, 1'b1, 1'b0);
    send(32'h0, 32'h0, 2'b11, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0);
    send(32'h1, 32'h0, 2'b10, 1'b0, 32'h1, 1'b0, 1'b1);
    send(32'h8000_0000, 32'h7FFF_FFFF, 2'b00, 1'b0, 32'h0, 1'b1, 1'b0);
    idle();
    drain();

    // Backpressure: only two beats fit, output holds steady.
    out_ready = 1'b0;
    accepted  = 0;
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1;
      a        = 32'h100 + 32'(accepted);
      b        = 32'h0;
      op       = 2'b10;
      acc_en   = 1'b0;
      @(negedge clk);
      if (in_ready) begin
        push_exp(32'h100 + 32'(accepted), 1'b0, (accepted == 0) ? 1'b1 : 1'b0);
        accepted++;
      end
      @(posedge clk);
      #1;
      if (c >= 1) begin
        check("bp_out_valid", 64'(out_valid), 64'd1);
        check("bp_result",    64'(result),    64'h100);
      end
    end
    check("bp_accepted", 64'(accepted), 64'd2);
    check("bp_in_ready", 64'(in_ready), 64'd0);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drain();

    // Reset with both stages full.
    send(32'h0, 32'h5, 2'b01, 1'b1, 32'h5, 1'b0, 1'b0);
    idle();
    drain();
    out_ready = 1'b0;
    send(32'h11, 32'h0, 2'b10, 1'b0, 32'h11, 1'b0, 1'b0);
    send(32'h22, 32'h0, 2'b10, 1'b0, 32'h22, 1'b0, 1'b0);
    in_valid = 1'b0;
    step();
    check("full_in_ready", 64'(in_ready),  64'd0);
    check("full_out_valid", 64'(out_valid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_in_ready",  64'(in_ready),  64'd1);
    check("mid_rst_result",    64'(result),    64'd0);
    check("mid_rst_zero",      64'(zero),      64'd1);
    exp_q.delete();
    @(posedge clk);
    #3;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    send(32'hFFFF_FFFF, 32'h0, 2'b01, 1'b1, 32'h0, 1'b1, 1'b0);
    idle();
    drain();
    repeat (3) step();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
